if_stage: RTL and testbench

//  Instruction-fetch stage, directly upstream of ID. Owns the PC and issues in-order

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/if_fifo.sv | 73 +++++++
 rtl/if_stage.sv | 178 +++++++++++++++++
 tb/tb_if_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch front end.
// Contents: XLEN, NOP encoding, default reset PC, IF state enum, fetch-buffer entry.
package riscv_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } if_state_t;

    // One buffered fetch: the word and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Fetch buffer: synchronous FIFO of {pc, instr} entries with flush.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, push_data write an entry (accepted when not full, or full with a pop)
//   pop             drop the head entry (ignored when empty)
//   flush           empty the FIFO; wins over push/pop
//   head            current head entry (valid when valid=1)
//   valid           FIFO non-empty
//   count           number of stored entries
module if_fifo
    import riscv_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pop needs data; push needs a free slot, which a same-cycle pop provides.
    assign do_pop  = pop & (count_q != '0);
    assign do_push = push & ((count_q != CNT_W'(DEPTH)) | do_pop);

    // Storage and pointer update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order fetches,
// buffers returned words with their PC and hands {instruction, pc} to ID.
// Redirects flush buffered words and drop responses still in flight.
// Optional macro IF_MISALIGN_TRAP_EN: misaligned redirect targets produce one
// faulting NOP entry (if_fault=1) and stall fetch until the next redirect;
// without it, target[1:0] is forced to zero.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       fetch request handshake
//   imem_rsp_valid/data             in-order fetch response
//   redirect_valid/target           EX redirect, highest priority
//   id_ready                        ID consumes the head this cycle
//   if_valid, instruction, pc_out,  head entry presented to ID
//   pc_plus4
//   if_fault                        (IF_MISALIGN_TRAP_EN only) head is a misaligned-target trap
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc_out,
`ifdef IF_MISALIGN_TRAP_EN
    output logic            if_fault,
`endif
    output logic [XLEN-1:0] pc_plus4
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    if_state_t        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;   // PC of the next response that will be kept
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] fifo_count;
    logic [XLEN-1:0]  target;
    logic             credit_ok;
    logic             req_hs;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fault_q;              // fetch stalled on a misaligned target
    logic             fault_pend_q;         // trap entry still to be written
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

`ifdef IF_MISALIGN_TRAP_EN
    logic fault_d, fault_pend_d;
    logic redirect_bad;

    assign target       = redirect_target;
    assign redirect_bad = (redirect_target[1:0] != 2'b00);

    // Trap state: a misaligned redirect arms one NOP entry and stalls fetch.
    always_comb begin
        fault_d      = fault_q;
        fault_pend_d = 1'b0;
        if (redirect_valid) begin
            fault_d      = redirect_bad;
            fault_pend_d = redirect_bad;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q      <= 1'b0;
            fault_pend_q <= 1'b0;
        end else begin
            fault_q      <= fault_d;
            fault_pend_q <= fault_pend_d;
        end
    end

    assign if_fault = if_valid & fault_q;
`else
    assign target       = redirect_target & ~XLEN'(3);
    assign fault_q      = 1'b0;
    assign fault_pend_q = 1'b0;
`endif

    // Credit counts both words in flight and words already buffered.
    assign credit_ok      = (SUM_W'(inflight_q) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);
    assign imem_req_valid = (state_q == RUN) & ~redirect_valid & ~fault_q & credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_hs         = imem_req_valid & imem_req_ready;
    assign fifo_pop       = if_valid & id_ready;

    // Next-state: FSM, PC, in-flight/drop accounting and FIFO push selection
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
        inflight_d = inflight_q + CNT_W'(req_hs) - CNT_W'(imem_rsp_valid);

        if (state_q == BOOT) begin
            state_d = RUN;
        end

        if (redirect_valid) begin
            // Everything still outstanding is stale, including a word arriving now.
            pc_d       = target;
            rsp_pc_d   = target;
            fifo_flush = 1'b1;
            drop_d     = inflight_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_hs) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else begin
                    fifo_push = 1'b1;
                    rsp_pc_d  = rsp_pc_q + 32'd4;
                end
            end
            // Any response in this cycle is covered by drop_q, so no push conflict.
            if (fault_pend_q) begin
                fifo_push  = 1'b1;
                push_entry = '{pc: pc_q, instr: NOP_INSTR};
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (head),
        .valid     (if_valid),
        .count     (fifo_count)
    );

    assign instruction = head.instr;
    assign pc_out      = head.pc;
    assign pc_plus4    = head.pc + 32'd4;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        id_ready = 1'b1;
    logic        if_valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
`ifdef IF_MISALIGN_TRAP_EN
    logic        if_fault;
`endif

    logic        mem_hold = 1'b0;
    logic [31:0] pend[$];
    logic [31:0] issued[$];
    logic [31:0] cons_pc[$];
    logic [31:0] cons_ins[$];

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_ready        (id_ready),
        .if_valid        (if_valid),
        .instruction     (instruction),
        .pc_out          (pc_out),
`ifdef IF_MISALIGN_TRAP_EN
        .if_fault        (if_fault),
`endif
        .pc_plus4        (pc_plus4)
    );

    always #5 clk = ~clk;

    // Memory model (in-order, data = ~addr, one response per cycle unless held)
    // and logs of issued addresses and consumed entries.
    always @(negedge clk) begin
        if (!rst) begin
            pend.delete();
            issued.delete();
            cons_pc.delete();
            cons_ins.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            if (!mem_hold && pend.size() > 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~pend.pop_front();
            end else begin
                imem_rsp_valid = 1'b0;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back(imem_req_addr);
                issued.push_back(imem_req_addr);
            end
            if (if_valid && id_ready) begin
                cons_pc.push_back(pc_out);
                cons_ins.push_back(instruction);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!if_valid && k < 30) begin
            step();
            k++;
        end
        check({tag, "_wait_valid"}, 32'(if_valid), 32'd1);
    endtask

    // Leaves the bench at posedge+1 of the first cycle after release (BOOT).
    task automatic do_reset();
        rst             = 1'b0;
        imem_req_ready  = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        id_ready        = 1'b1;
        mem_hold        = 1'b0;
        step_n(3);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int n_iss;

        // Reset values
        step_n(2);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr",  imem_req_addr, 32'h0);
        check("rst_if_valid",  32'(if_valid), 32'd0);
        check("rst_instr",     instruction, 32'h0);
        check("rst_pc_out",    pc_out, 32'h0);
        check("rst_pc_plus4",  pc_plus4, 32'h4);
`ifdef IF_MISALIGN_TRAP_EN
        check("rst_if_fault",  32'(if_fault), 32'd0);
`endif

        // 1: boot cycle, first request, streaming order
        do_reset();
        #1 check("t1_boot_no_req", 32'(imem_req_valid), 32'd0);
        step();
        #1 check("t1_first_req", 32'(imem_req_valid), 32'd1);
        check("t1_first_addr", imem_req_addr, 32'h0);
        step_n(2);
        #1 check("t1_first_valid", 32'(if_valid), 32'd1);
        check("t1_first_pc", pc_out, 32'h0);
        check("t1_first_instr", instruction, 32'hFFFF_FFFF);
        check("t1_first_pc4", pc_plus4, 32'h4);
        step_n(12);
        check("t1_pc0", cons_pc[0], 32'h0);
        check("t1_pc1", cons_pc[1], 32'h4);
        check("t1_pc2", cons_pc[2], 32'h8);
        check("t1_ins2", cons_ins[2], 32'hFFFF_FFF7);

        // 2: backpressure from ID
        do_reset();
        id_ready = 1'b0;
        step_n(7);
        #1 check("t2_issued", 32'(issued.size()), 32'd2);
        check("t2_req_off", 32'(imem_req_valid), 32'd0);
        check("t2_valid", 32'(if_valid), 32'd1);
        check("t2_head_pc", pc_out, 32'h0);
        step_n(2);
        #1 check("t2_head_pc_hold", pc_out, 32'h0);
        check("t2_head_ins_hold", instruction, 32'hFFFF_FFFF);
        id_ready = 1'b1;
        step_n(12);
        check("t2_pc0", cons_pc[0], 32'h0);
        check("t2_pc1", cons_pc[1], 32'h4);
        check("t2_pc2", cons_pc[2], 32'h8);

        // 3: redirect with two fetches in flight
        do_reset();
        mem_hold = 1'b1;
        step_n(3);
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        #1 check("t3_issued", 32'(issued.size()), 32'd2);
        step();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        id_ready       = 1'b0;
        #1 check("t3_flushed", 32'(if_valid), 32'd0);
        wait_valid("t3");
        check("t3_pc", pc_out, 32'h100);
        check("t3_pc4", pc_plus4, 32'h104);
        check("t3_ins", instruction, 32'hFFFF_FEFF);

        // 3b: second redirect while drops are still pending
        do_reset();
        mem_hold = 1'b1;
        step_n(3);
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        step();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        step();
        mem_hold = 1'b1;
        #1 check("t3b_req", 32'(imem_req_valid), 32'd1);
        check("t3b_addr", imem_req_addr, 32'h100);
        step();
        redirect_valid  = 1'b1;
        redirect_target = 32'h180;
        step();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        id_ready       = 1'b0;
        wait_valid("t3b");
        check("t3b_pc", pc_out, 32'h180);
        check("t3b_ins", instruction, 32'hFFFF_FE7F);

        // 4: redirect in the same cycle as a response
        do_reset();
        step_n(2);
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        #1 check("t4_no_req_redirect", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        #1 check("t4_word_dropped", 32'(if_valid), 32'd0);
        check("t4_issued", 32'(issued.size()), 32'd1);
        check("t4_req_next", 32'(imem_req_valid), 32'd1);
        check("t4_addr_next", imem_req_addr, 32'h300);
        wait_valid("t4");
        check("t4_pc", pc_out, 32'h300);
        check("t4_ins", instruction, 32'hFFFF_FCFF);

        // 5: imem_req_ready toggling
        do_reset();
        step();
        step();
        imem_req_ready = 1'b0;
        #1 check("t5_hold_valid", 32'(imem_req_valid), 32'd1);
        check("t5_hold_addr", imem_req_addr, 32'h4);
        step();
        imem_req_ready = 1'b1;
        #1 check("t5_retry_addr", imem_req_addr, 32'h4);
        step_n(10);
        check("t5_iss0", issued[0], 32'h0);
        check("t5_iss1", issued[1], 32'h4);
        check("t5_iss2", issued[2], 32'h8);
        check("t5_iss3", issued[3], 32'hC);
        check("t5_pc1", cons_pc[1], 32'h4);

        // 6: misaligned redirect target
        do_reset();
        step_n(5);
        redirect_valid  = 1'b1;
        redirect_target = 32'h102;
        step();
        redirect_valid = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        n_iss = issued.size();
        #1 check("t6_no_req", 32'(imem_req_valid), 32'd0);
        wait_valid("t6");
        check("t6_fault", 32'(if_fault), 32'd1);
        check("t6_nop", instruction, NOP_INSTR);
        check("t6_pc", pc_out, 32'h102);
        step_n(8);
        check("t6_stalled", 32'(issued.size()), 32'(n_iss));
        check("t6_one_entry", 32'(if_valid), 32'd0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        step();
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        wait_valid("t6_resume");
        check("t6_resume_pc", pc_out, 32'h200);
        check("t6_resume_ins", instruction, 32'hFFFF_FDFF);
        check("t6_resume_fault", 32'(if_fault), 32'd0);
`else
        n_iss = 0;
        id_ready = 1'b0;
        #1 check("t6_req_aligned", imem_req_addr, 32'h100 + 32'(n_iss));
        wait_valid("t6");
        check("t6_pc", pc_out, 32'h100);
        check("t6_ins", instruction, 32'hFFFF_FEFF);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
